instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of the decoder. Keeps the program counter and issues word reads to instruction
//  memory over a req/ack handshake. Responses are buffered in a small prefetch FIFO.
//  Drives InstructionBus into the decoder, which has no valid input, so empty slots are sent as NOP bubbles.
//  Takes branch redirects from the execute stage and flushes the fetch path on each one.
// PARAMETERS
//  ADDR_W    24          width of PC / memory word address (matches 24-bit literal field)
//  DEPTH     2           prefetch FIFO entries (power of two, >=2)
//  RESET_PC  0           PC value loaded on reset
//  NOP_INSTR 32'h000000FF bubble word; opcode 255 = "pass instruction only", no register side effects
// PORTS
//  clk            in  1       system clock, all state on posedge
//  rst            in  1       asynchronous reset, active-high
//  MemReq         out 1       read request; held until MemAck
//  MemAddr        out ADDR_W  word address; stable while MemReq=1
//  MemAck         in  1       one-cycle acknowledge; MemData valid in the same cycle
//  MemData        in  32      instruction word
//  Stall          in  1       downstream hold: InstructionBus/PcOut/InstrValid must not change
//  BranchValid    in  1       redirect request (single-cycle pulse)
//  BranchTarget   in  ADDR_W  redirect address
//  InstructionBus out 32      instruction to decoder
//  InstrValid     out 1       InstructionBus carries a fetched instruction (0 = bubble)
//  PcOut          out ADDR_W  address of the instruction on InstructionBus (0 on bubble)
// BEHAVIOUR
//  Reset (async, any state): PC=RESET_PC, FIFO empty, state=S_REQ, MemReq=0, MemAddr=RESET_PC,
//   InstructionBus=NOP_INSTR, InstrValid=0, PcOut=0. Any in-flight memory response is forgotten.
//  FSM states:
//   S_REQ:     MemReq=1, MemAddr=PC.
//              On MemAck: push {PC,MemData} and set PC=PC+1 (mod 2^ADDR_W).
//              Stay in S_REQ if the FIFO still has a free slot after the push and pop of that edge, else go to S_FULL.
//   S_FULL:    MemReq=0. Return to S_REQ on the first edge where a slot is free.
//              MemReq rises on the cycle after that edge.
//   S_DISCARD: MemReq=1, MemAddr = old address (held). On MemAck: drop MemData and go to S_REQ.
//  MemReq rule: MemReq is never deasserted before MemAck while a request is outstanding.
//  Output stage (register), when Stall=0:
//   - FIFO non-empty: pop the head into InstructionBus/PcOut, InstrValid=1.
//   - FIFO empty: load the bubble (NOP_INSTR, PcOut=0, InstrValid=0).
//  When Stall=1 the output stage holds and the FIFO does not pop. Fetching continues until the FIFO is full.
//  Latency:
//   - data is written to the FIFO at the MemAck edge;
//   - it reaches InstructionBus at the next un-stalled edge, at the earliest 1 cycle after MemAck.
//   - The FIFO is not bypassed.
//  Throughput: with MemAck held high, one instruction per cycle in steady state.
//  Simultaneous push and pop when the FIFO is full or empty are both legal. Occupancy is unchanged on a full FIFO.
//  BranchValid (priority over Stall and over MemAck), at its edge:
//   - FIFO flushed; output stage loads the bubble; PC=BranchTarget.
//   - In S_REQ without MemAck this cycle: go to S_DISCARD. MemAddr keeps the old address until its ack.
//     Only after that does MemAddr change to BranchTarget.
//   - In S_REQ with MemAck this cycle: the data is dropped; next state is S_REQ with MemAddr=BranchTarget.
//   - In S_FULL: next state is S_REQ.
//   - In S_DISCARD: stay in S_DISCARD; PC takes the newer target.
//  PC wrap: {ADDR_W{1'b1}}+1 -> 0, silently.
// STRUCTURE
//  Shared package apcpu_pkg: NOP_INSTR, ADDR_W default, fetch FSM state encoding (S_REQ/S_FULL/S_DISCARD).
//  One sub-module: fetch_fifo.
//   - Synchronous FIFO, DEPTH x (ADDR_W+32).
//   - Ports: push, pop, flush, full, empty, head data.
//   - Wrap-around read/write pointers plus a count.
//   - flush has priority over push.
//  The top level holds the PC, the FSM, the output register and the glue.
// TESTING
//  T1 Reset: assert rst mid-cycle -> immediately MemReq=0, InstructionBus=32'h000000FF, InstrValid=0.
//     After release, MemReq=1 with MemAddr=0.
//  T2 Streaming: MemAck held 1, memory returns addr+32'h100 -> InstructionBus carries 0x100, 0x101, ...
//     One per cycle; PcOut=0,1,...; no bubbles after the first.
//  T3 Stall: raise Stall for 6 cycles while streaming -> outputs frozen; MemReq drops once 2 entries are held.
//     On release, outputs continue in order with no loss or duplication.
//  T4 Branch during pending request:
//     Setup: MemAck delayed 3 cycles; BranchValid with target 0x40 while the read at 0x05 is pending.
//     Required response:
//      - MemAddr stays 0x05 until its ack, and that data never appears at the output;
//      - the next request is for 0x40;
//      - bubbles appear until 0x40 arrives.
//  T5 Branch, ack and stall at the same edge: BranchValid, MemAck and Stall all 1 -> FIFO empty and output a bubble.
//     The acked word is dropped; the next MemAddr is the target.
//  T6 Wrap: BranchTarget=24'hFFFFFF, streaming -> PcOut sequence FFFFFF, 000000, 000001.

Source files
------------

// File: rtl/apcpu_pkg.sv
// Shared fetch-stage definitions: default widths, bubble word and fetch FSM encoding.
package apcpu_pkg;

  localparam int unsigned DEF_ADDR_W    = 24;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_00FF;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_FULL    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: req/ack handshake with single-cycle data return.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = apcpu_pkg::DEF_ADDR_W
);

  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemAck;
  logic [31:0]       MemData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemAck,
    input  MemData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemAck,
    output MemData
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO: wrap-around pointers plus occupancy count; flush wins over push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 56,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign level     = cnt_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_pop_c  = pop && !empty && !flush;
  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_push_c = push && !flush && (!full || do_pop_c);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, memory request FSM, prefetch FIFO and decoder-facing output register.
module instruction_fetch
  import apcpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master mem,
  input  logic                Stall,
  input  logic                BranchValid,
  input  logic [ADDR_W-1:0]   BranchTarget,
  output logic [31:0]         InstructionBus,
  output logic                InstrValid,
  output logic [ADDR_W-1:0]   PcOut
);

  localparam int unsigned ENTRY_W = ADDR_W + 32;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pcout_q, pcout_d;

  logic               ack_c;
  logic               push_c;
  logic               pop_c;
  logic [CNT_W:0]     level_next_c;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_level;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (BranchValid),
    .wdata ({pc_q, mem.MemData}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state, PC, request and output-stage decisions; redirects dominate everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bus_d   = bus_q;
    valid_d = valid_q;
    pcout_d = pcout_q;

    // An ack only counts while a request is actually on the bus.
    ack_c  = mem.MemAck && req_q;
    push_c = (state_q == S_REQ) && ack_c && !BranchValid;
    pop_c  = !BranchValid && !Stall && !fifo_empty;
    level_next_c = {1'b0, fifo_level} + (CNT_W + 1)'(push_c) - (CNT_W + 1)'(pop_c);

    unique case (state_q)
      S_REQ: begin
        if (BranchValid) begin
          pc_d    = BranchTarget;
          state_d = (req_q && !ack_c) ? S_DISCARD : S_REQ;
        end else if (ack_c) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (level_next_c < (CNT_W + 1)'(DEPTH)) ? S_REQ : S_FULL;
        end
      end
      S_FULL: begin
        if (BranchValid) begin
          pc_d    = BranchTarget;
          state_d = S_REQ;
        end else if (pop_c || !fifo_full) begin
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (BranchValid) pc_d = BranchTarget;
        // The stale response completes the abandoned read; fetch resumes from the latest target.
        if (ack_c) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Request stays up in every state except S_FULL; a discarded read keeps its address.
    req_d  = (state_d != S_FULL);
    addr_d = (state_d == S_DISCARD) ? addr_q : pc_d;

    if (BranchValid) begin
      bus_d   = NOP_INSTR;
      valid_d = 1'b0;
      pcout_d = '0;
    end else if (!Stall) begin
      if (!fifo_empty) begin
        bus_d   = fifo_rdata[31:0];
        valid_d = 1'b1;
        pcout_d = fifo_rdata[ENTRY_W-1:32];
      end else begin
        bus_d   = NOP_INSTR;
        valid_d = 1'b0;
        pcout_d = '0;
      end
    end
  end

  // State, PC, memory port and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      bus_q   <= NOP_INSTR;
      valid_q <= 1'b0;
      pcout_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      pcout_q <= pcout_d;
    end
  end

  assign mem.MemReq     = req_q;
  assign mem.MemAddr    = addr_q;
  assign InstructionBus = bus_q;
  assign InstrValid     = valid_q;
  assign PcOut          = pcout_q;

endmodule
